// File: rtl/fwrisc_trace_pkg.sv
// Shared types for the fwrisc trace collector: event kinds, the queued
// event record and the drop-counter width.
package fwrisc_trace_pkg;

  typedef enum logic [1:0] {
    EV_EXEC = 2'd0,
    EV_REGW = 2'd1,
    EV_MEMR = 2'd2,
    EV_MEMW = 2'd3
  } ev_kind_t;

  // 2 + 32 + 32 + 4 = 70 bits
  typedef struct packed {
    ev_kind_t    kind;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  strb;
  } ev_rec_t;

  localparam int DROP_CNT_W = 16;
  localparam int MAX_WR     = 3;

  function automatic ev_rec_t make_rec(ev_kind_t k, logic [31:0] a,
                                       logic [31:0] b, logic [3:0] s);
    ev_rec_t r;
    r.kind = k;
    r.a    = a;
    r.b    = b;
    r.strb = s;
    return r;
  endfunction

endpackage

// File: rtl/fwrisc_trace_collector_if.sv
// Event stream bundle from the trace FIFO head to its consumer.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; while valid is high and ready low, rec holds steady.
interface fwrisc_trace_collector_if;

  logic                     valid;
  logic                     ready;
  fwrisc_trace_pkg::ev_rec_t rec;

  modport master (output valid, output rec, input ready);
  modport slave  (input valid, input rec, output ready);

endinterface

// File: rtl/fwrisc_trace_fifo_mw.sv
// Multi-write event FIFO: up to three entries written per edge in port order,
// one first-word-fall-through read port.
module fwrisc_trace_fifo_mw
  import fwrisc_trace_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter type rec_t = ev_rec_t
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [1:0]               wr_cnt,
  input  rec_t                     wr_data [MAX_WR],
  output logic [$clog2(DEPTH):0]   count,
  fwrisc_trace_collector_if.master rd
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  rec_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_idx [MAX_WR];
  logic             deq;

  assign rd.valid = (count != '0);
  assign rd.rec   = mem[rd_ptr];
  assign deq      = rd.valid && rd.ready;

  always_comb begin
    for (int i = 0; i < MAX_WR; i++) begin
      wr_idx[i] = wr_ptr + PTR_W'(i);
    end
  end

  // Storage carries no reset; only pointers and occupancy define contents.
  always_ff @(posedge clock) begin
    for (int i = 0; i < MAX_WR; i++) begin
      if (i < int'(wr_cnt)) begin
        mem[wr_idx[i]] <= wr_data[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(wr_cnt);
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(wr_cnt) - CNT_W'(deq);
    end
  end

endmodule

// File: rtl/fwrisc_trace_collector.sv
// Collects EXEC/REGW/MEM trace events each cycle, admits them atomically
// into the event FIFO and tracks dropped events.
module fwrisc_trace_collector
  import fwrisc_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           addr,
  input  logic [31:0]           instr,
  input  logic                  ivalid,
  input  logic [31:0]           raddr,
  input  logic [31:0]           rdata,
  input  logic                  rwrite,
  input  logic [31:0]           maddr,
  input  logic [31:0]           mdata,
  input  logic [3:0]            mstrb,
  input  logic                  mwrite,
  input  logic                  mvalid,
  output logic                  ev_valid,
  input  logic                  ev_ready,
  output logic [1:0]            ev_kind,
  output logic [31:0]           ev_a,
  output logic [31:0]           ev_b,
  output logic [3:0]            ev_strb,
  input  logic                  ovf_clr,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  ev_rec_t                src   [MAX_WR];
  logic                   src_v [MAX_WR];
  ev_rec_t                comp  [MAX_WR];
  logic [1:0]             n_ev;
  logic [1:0]             wr_cnt;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       space;
  logic                   drop;
  logic [DROP_CNT_W:0]    dc_sum;
  logic [DROP_CNT_W-1:0]  n_ext;

  fwrisc_trace_collector_if ev_bus ();

  always_comb begin
    src[0]   = make_rec(EV_EXEC, addr, instr, 4'h0);
    src[1]   = make_rec(EV_REGW, raddr, rdata, 4'h0);
    src[2]   = make_rec(mwrite ? EV_MEMW : EV_MEMR, maddr, mdata, mstrb);
    src_v[0] = ivalid;
    src_v[1] = rwrite;
    src_v[2] = mvalid;
  end

  // Pack the active sources into consecutive write slots, preserving order.
  always_comb begin
    n_ev = 2'd0;
    for (int i = 0; i < MAX_WR; i++) begin
      comp[i] = '0;
    end
    for (int i = 0; i < MAX_WR; i++) begin
      if (src_v[i]) begin
        comp[n_ev] = src[i];
        n_ev       = n_ev + 2'd1;
      end
    end
  end

  // Space is judged on pre-edge occupancy; a same-cycle dequeue does not help.
  assign space  = CNT_W'(DEPTH) - count;
  assign drop   = ({{(CNT_W-2){1'b0}}, n_ev} > space);
  assign wr_cnt = drop ? 2'd0 : n_ev;

  assign n_ext  = {{(DROP_CNT_W-2){1'b0}}, n_ev};
  assign dc_sum = {1'b0, drop_count} + {1'b0, n_ext};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (ovf_clr) begin
      overflow   <= drop;
      drop_count <= drop ? n_ext : '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      drop_count <= dc_sum[DROP_CNT_W] ? '1 : dc_sum[DROP_CNT_W-1:0];
    end
  end

  fwrisc_trace_fifo_mw #(
    .DEPTH (DEPTH),
    .rec_t (ev_rec_t)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_cnt  (wr_cnt),
    .wr_data (comp),
    .count   (count),
    .rd      (ev_bus)
  );

  assign ev_bus.ready = ev_ready;
  assign ev_valid     = ev_bus.valid;
  assign ev_kind      = ev_bus.rec.kind;
  assign ev_a         = ev_bus.rec.a;
  assign ev_b         = ev_bus.rec.b;
  assign ev_strb      = ev_bus.rec.strb;

endmodule

// File: tb/tb_fwrisc_trace_collector.sv
// Self-checking bench for fwrisc_trace_collector: directed scenarios plus
// random traffic, compared against a queue-based reference model.
module tb_fwrisc_trace_collector;
  import fwrisc_trace_pkg::*;

  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr, instr, raddr, rdata, maddr, mdata;
  logic [3:0]  mstrb;
  logic        ivalid, rwrite, mwrite, mvalid, ovf_clr;
  logic [1:0]  ev_kind;
  logic [31:0] ev_a, ev_b;
  logic [3:0]  ev_strb;
  logic        overflow;
  logic [15:0] drop_count;

  fwrisc_trace_collector_if mon ();

  fwrisc_trace_collector #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .addr(addr), .instr(instr), .ivalid(ivalid),
    .raddr(raddr), .rdata(rdata), .rwrite(rwrite),
    .maddr(maddr), .mdata(mdata), .mstrb(mstrb),
    .mwrite(mwrite), .mvalid(mvalid),
    .ev_valid(mon.valid), .ev_ready(mon.ready),
    .ev_kind(ev_kind), .ev_a(ev_a), .ev_b(ev_b), .ev_strb(ev_strb),
    .ovf_clr(ovf_clr), .overflow(overflow), .drop_count(drop_count)
  );

  // clock/reset
  always #5 clock = ~clock;

  // reference model state
  logic [69:0] exp_q[$];
  bit          m_ovf;
  int          m_dc;
  int          checks   = 0;
  int          failures = 0;

  function automatic logic [69:0] rec(logic [1:0] k, logic [31:0] a,
                                      logic [31:0] b, logic [3:0] s);
    return {k, a, b, s};
  endfunction

  task automatic chk(string tag, logic [69:0] got, logic [69:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, "/valid"}, {69'd0, mon.valid}, {69'd0, exp_q.size() != 0});
    if (exp_q.size() != 0)
      chk({tag, "/head"}, {ev_kind, ev_a, ev_b, ev_strb}, exp_q[0]);
    chk({tag, "/overflow"}, {69'd0, overflow}, {69'd0, m_ovf});
    chk({tag, "/drop_count"}, {54'd0, drop_count}, 70'(m_dc));
  endtask

  // driver tasks
  task automatic drive(bit iv, bit rw, bit mv, bit mw);
    ivalid = iv; rwrite = rw; mvalid = mv; mwrite = mw;
    addr  = $urandom; instr = $urandom;
    raddr = $urandom; rdata = $urandom;
    maddr = $urandom; mdata = $urandom;
    mstrb = 4'($urandom_range(0, 15));
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Apply the model's rules for the coming edge, take the edge, then check.
  task automatic step(string tag);
    logic [69:0] list[$];
    int          sz, n;
    bit          deq, drp;
    sz  = exp_q.size();
    deq = (sz != 0) && mon.ready;
    if (ivalid) list.push_back(rec(2'd0, addr, instr, 4'h0));
    if (rwrite) list.push_back(rec(2'd1, raddr, rdata, 4'h0));
    if (mvalid) list.push_back(rec(mwrite ? 2'd3 : 2'd2, maddr, mdata, mstrb));
    n   = list.size();
    drp = (n > DEPTH - sz);
    if (deq) void'(exp_q.pop_front());
    if (!drp) foreach (list[i]) exp_q.push_back(list[i]);
    if (ovf_clr) begin
      m_ovf = drp;
      m_dc  = drp ? n : 0;
    end else if (drp) begin
      m_ovf = 1'b1;
      m_dc  = (m_dc + n > 65535) ? 65535 : m_dc + n;
    end
    @(posedge clock);
    @(negedge clock);
    check_all(tag);
  endtask

  initial begin
    ovf_clr  = 1'b0;
    mon.ready = 1'b0;
    m_ovf    = 1'b0;
    m_dc     = 0;
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (3) @(negedge clock);
    check_all("reset");
    idle();
    reset = 1'b1;

    // single EXEC, one-cycle latency, then empty
    mon.ready = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    addr = 32'h100; instr = 32'h13;
    step("r29_a");
    chk("r29_kind", {68'd0, ev_kind}, 70'd0);
    chk("r29_ev_a", {38'd0, ev_a}, 70'h100);
    chk("r29_ev_b", {38'd0, ev_b}, 70'h13);
    idle();
    step("r29_b");
    chk("r29_empty", {69'd0, mon.valid}, 70'd0);

    // three events in one cycle come out in fixed order
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    raddr = 32'd5; rdata = 32'hA5;
    maddr = 32'h2000; mdata = 32'hDEADBEEF; mstrb = 4'hF;
    step("r30_exec");
    chk("r30_k0", {68'd0, ev_kind}, 70'd0);
    idle();
    step("r30_regw");
    chk("r30_regw", {ev_kind, ev_a, ev_b, ev_strb}, rec(2'd1, 32'd5, 32'hA5, 4'h0));
    step("r30_memw");
    chk("r30_memw", {ev_kind, ev_a, ev_b, ev_strb},
        rec(2'd3, 32'h2000, 32'hDEADBEEF, 4'hF));
    step("r30_done");
    chk("r30_empty", {69'd0, mon.valid}, 70'd0);

    // backpressure holds the head
    mon.ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0); step("r32_fill");
    drive(1'b0, 1'b0, 1'b1, 1'b0); step("r32_fill");
    drive(1'b1, 1'b0, 1'b0, 1'b0); step("r32_fill");
    idle();
    repeat (5) step("r32_hold");
    mon.ready = 1'b1;
    repeat (4) step("r32_drain");
    chk("r32_empty", {69'd0, mon.valid}, 70'd0);

    // atomic admission at the full boundary
    mon.ready = 1'b0;
    repeat (4) begin drive(1'b1, 1'b1, 1'b1, 1'($urandom_range(0, 1))); step("r31_fill"); end
    drive(1'b1, 1'b1, 1'b0, 1'b0); step("r31_fill14");
    drive(1'b1, 1'b1, 1'b1, 1'b0); step("r31_drop3");
    chk("r31_ovf", {69'd0, overflow}, 70'd1);
    chk("r31_dc3", {54'd0, drop_count}, 70'd3);
    drive(1'b0, 1'b1, 1'b1, 1'b1); step("r31_fit2");
    drive(1'b1, 1'b0, 1'b0, 1'b0); step("r31_full_drop");
    chk("r31_dc4", {54'd0, drop_count}, 70'd4);

    // clear coinciding with a drop, then a plain clear
    ovf_clr = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b0); step("clr_drop");
    chk("clr_drop_dc", {54'd0, drop_count}, 70'd3);
    idle(); step("clr_plain");
    ovf_clr = 1'b0;
    chk("clr_ovf0", {69'd0, overflow}, 70'd0);
    mon.ready = 1'b1;
    repeat (17) step("drain1");

    // pointer wrap with toggling ready
    for (int i = 0; i < 40; i++) begin
      mon.ready = 1'b1; drive(1'b1, 1'b0, 1'b0, 1'b0); step("r33_ev");
      mon.ready = 1'b0; idle(); step("r33_gap");
    end
    mon.ready = 1'b1; idle(); step("r33_end");
    chk("r33_dc0", {54'd0, drop_count}, 70'd0);

    // random traffic, light then heavy
    repeat (400) begin
      mon.ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 31) == 0);
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      step("rand_lo");
    end
    repeat (400) begin
      mon.ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step("rand_hi");
    end

    // drop counter saturation
    mon.ready = 1'b0;
    ovf_clr = 1'b1; idle(); step("sat_clr");
    ovf_clr = 1'b0;
    repeat (21850) begin drive(1'b1, 1'b1, 1'b1, 1'b1); step("sat"); end
    chk("sat_ffff", {54'd0, drop_count}, 70'hFFFF);

    // async reset mid-operation with 7 queued and overflow set
    mon.ready = 1'b1; idle();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() <= 7) break;
      step("r34_drain");
    end
    mon.ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("r34_valid0", {69'd0, mon.valid}, 70'd0);
    chk("r34_ovf0", {69'd0, overflow}, 70'd0);
    chk("r34_dc0", {54'd0, drop_count}, 70'd0);
    exp_q.delete(); m_ovf = 1'b0; m_dc = 0;
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (3) @(negedge clock);
    check_all("r34_held");
    idle();
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    step("r34_first");
    mon.ready = 1'b1; idle();
    step("r34_alone");
    chk("r34_alone_empty", {69'd0, mon.valid}, 70'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
